// File: rtl/node_pkg.sv
// Shared layer constants, deserializer state encoding and the a_vec word-slice helper.
package node_pkg;
  localparam int DATA_W = 16;
  localparam int N_IN   = 10;
  localparam int CNT_W  = $clog2(N_IN);

  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

  function automatic int word_lsb(input int k);
    return k * DATA_W;
  endfunction
endpackage

// File: rtl/layer_input_deserializer_pulse_delay.sv
// LAT-stage shift register; every input pulse reappears exactly LAT cycles later.
module pulse_delay #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  logic [LAT-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= in;
      for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign out = r_sr[LAT-1];
endmodule

// File: rtl/layer_input_deserializer.sv
// Collects a serial activation stream into the node's parallel N_IN-word input vector.
module layer_input_deserializer
  import node_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_last,
  input  logic                   hold,
  output logic [N_IN*DATA_W-1:0] a_vec,
  output logic                   vec_valid,
  output logic                   res_strobe,
  output logic                   err_short,
  output logic                   err_long
);
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [N_IN*DATA_W-1:0] r_shadow;
  logic [N_IN*DATA_W-1:0] r_avec;
  logic                   r_ovl;
  logic                   r_vv;
  logic                   r_es;
  logic                   r_el;

  logic                   w_accept;
  logic                   w_last_slot;
  logic                   w_final;
  logic [N_IN*DATA_W-1:0] w_next_vec;

  assign s_ready     = (r_state != FULL) && !reset;
  assign w_accept    = s_valid && s_ready;
  assign w_last_slot = (r_cnt == CNT_W'(N_IN - 1));
  assign w_final     = s_last || w_last_slot;

  // Shadow words above cnt are always zero, which gives the zero-fill of short vectors for free.
  always_comb begin
    w_next_vec = r_shadow;
    for (int k = 0; k < N_IN; k++) begin
      if (r_cnt == CNT_W'(k)) w_next_vec[word_lsb(k) +: DATA_W] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FILL;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_avec   <= '0;
      r_ovl    <= 1'b0;
      r_vv     <= 1'b0;
      r_es     <= 1'b0;
      r_el     <= 1'b0;
    end else begin
      r_vv <= 1'b0;
      r_es <= 1'b0;
      r_el <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_final) begin
              r_es <= s_last && !w_last_slot;
              r_el <= !s_last;
              if (hold) begin
                r_shadow <= w_next_vec;
                r_ovl    <= !s_last;
                r_state  <= FULL;
              end else begin
                r_avec   <= w_next_vec;
                r_vv     <= 1'b1;
                r_shadow <= '0;
                r_cnt    <= '0;
                r_state  <= s_last ? FILL : DRAIN;
              end
            end else begin
              r_shadow <= w_next_vec;
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (!hold) begin
            r_avec   <= r_shadow;
            r_vv     <= 1'b1;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_ovl    <= 1'b0;
            r_state  <= r_ovl ? DRAIN : FILL;
          end
        end
        DRAIN: begin
          if (w_accept && s_last) r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign a_vec     = r_avec;
  assign vec_valid = r_vv;
  assign err_short = r_es;
  assign err_long  = r_el;

  pulse_delay #(.LAT(LAT)) u_strobe_dly (
    .clk   (clk),
    .reset (reset),
    .in    (r_vv),
    .out   (res_strobe)
  );
endmodule

// File: doc/layer_input_deserializer.md
# layer_input_deserializer

Assembles a serial stream of 16-bit activations into the parallel 10-word input vector consumed by a dense-layer node (ports A0x..A9x). It holds the vector stable for the node and emits a result strobe when the node's registered ReLU output is valid. It sits between the sample/feature source and each layer-3 node bank, with one instance shared by all nodes of a layer.

## Interface
- N_IN, 10, words per input vector
- DATA_W, 16, word width (two's complement)
- LAT, 3, node latency in cycles from a_vec update to a valid node output
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid && s_ready
- s_data  in  DATA_W  activation word; first accepted word → A0x
- s_last  in  1  marks final word of a vector
- hold  in  1  downstream stall; blocks commit of a new vector
- a_vec  out  N_IN*DATA_W  parallel vector; word k at bits [16k+15:16k], drives Akx
- vec_valid  out  1  one-cycle pulse; a_vec changed this cycle
- res_strobe  out  1  one-cycle pulse LAT cycles after vec_valid
- err_short  out  1  one-cycle pulse; vector ended before N_IN words
- err_long  out  1  one-cycle pulse; N_IN words reached without s_last

## Operation
- The shadow buffer (N_IN×DATA_W) and word counter cnt (0..N_IN-1) fill from the stream.
- States: FILL, FULL, DRAIN.
- FILL: s_ready=1. An accepted word is written to shadow[cnt].
  - Final word is either s_last, or cnt==N_IN-1.
  - Final word with hold=0: commit at the same edge; a_vec gets shadow plus the final word. Stay in FILL, or go to DRAIN if overlong.
  - Final word with hold=1: go to FULL.
  - Otherwise cnt++.
- Short vector (s_last with cnt<N_IN-1): words cnt+1..N_IN-1 are zero-filled in the committed vector; err_short pulses.
- Overlong (cnt==N_IN-1 without s_last): the vector commits normally; err_long pulses once; the next state is DRAIN.
- FULL: s_ready=0. When hold=0, commit, then go to DRAIN if the overlong flag is set, else FILL.
- DRAIN: s_ready=1. Accepted words are discarded. Leave for FILL after the s_last word is accepted. No further errors are flagged.
- Commit:
  - a_vec updates and vec_valid=1 in the following cycle.
  - cnt clears; the shadow buffer clears to 0.
- res_strobe is vec_valid delayed LAT cycles through a LAT-bit shift register. Overlapping strobes are preserved, and every vec_valid yields exactly one res_strobe.
- Node outputs are sampled by the consumer on res_strobe. The node treats negative sums as 0; this block does no arithmetic.
- Reset values:
  - a_vec=0, vec_valid=0, res_strobe=0, err_short=0, err_long=0.
  - state=FILL, cnt=0, shadow=0, delay line=0.
  - s_ready=0 while reset=1.
- Reset mid-vector discards partial words and pending strobes.

## Timing
- s_ready is combinational: (state!=FULL) && !reset. All other outputs are registered.
- Final word accepted at edge t with hold=0: a_vec and vec_valid are visible after t, and res_strobe follows LAT edges later.
- Minimum spacing between commits is N_IN cycles for full vectors, or 1 cycle for single-word s_last vectors.
- a_vec is stable between commits, including during FULL and DRAIN.
- hold only affects commit; hold=1 during FILL before the final word has no effect.
- A commit from FULL occurs at the first edge with hold=0. No words are accepted in that cycle.
- s_last on word N_IN-1 is a normal full vector: no error, stay in FILL.

## Structure
- A shared package node_pkg holds:
  - DATA_W=16 and N_IN=10
  - the state enum {FILL, FULL, DRAIN}
  - the a_vec word-slice index helper
- One sub-module: pulse_delay (parameter LAT, input in, output out), the shift-register delay line for res_strobe, reset to zero.

## Test plan
- 10 words 1..10, s_last on the 10th, hold=0 → vec_valid after word 10; a_vec word k = k+1; res_strobe 3 cycles later; no errors.
- 4 words 0x7FFF, 0x8000, 5, 6 with s_last on the 4th → a_vec words 0..3 match, words 4..9 = 0; err_short pulses once.
- 13 words with s_last on the 13th → commit of words 0..9 after the 10th; err_long on the same cycle as vec_valid; words 11..13 discarded; the next vector is captured intact.
- hold=1 while vector 2 completes → s_ready=0 and a_vec keeps vector 1. Release hold → vector 2 commits in the next cycle; s_ready=1 the cycle after.
- Back-to-back single-word s_last vectors 0xAAAA, 0x5555 → two vec_valid pulses on consecutive cycles; two res_strobe pulses 3 cycles after each.
- Reset asserted after 5 words → s_ready=0 during reset; all outputs 0; the following 10-word vector commits with no stale data.
